// File: rtl/branch_pkg.sv
// Shared constants and types for the execute-stage branch resolver.
// Optional perf counters: BRANCH_PERF_COUNTER_EN.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } branch_state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-stage <-> branch resolver bundle.
// Counter signals exist only with BRANCH_PERF_COUNTER_EN.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
`ifdef BRANCH_PERF_COUNTER_EN
  , parameter int CNT_W = 32
`endif
);

  logic            stall;
  logic            flush;
  logic            valid;
  logic            isBranch;
  logic            isJal;
  logic            isJalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1Value;
  logic [XLEN-1:0] rs2Value;
  logic [XLEN-1:0] programCounter;
  logic [XLEN-1:0] immediate;

  logic            shouldBranch;
  logic [XLEN-1:0] branchTarget;
  logic [XLEN-1:0] linkAddress;
  logic            misaligned;

`ifdef BRANCH_PERF_COUNTER_EN
  logic [CNT_W-1:0] branchCount;
  logic [CNT_W-1:0] takenCount;

  modport master (
    output stall, flush, valid,
    output isBranch, isJal, isJalr,
    output funct3, rs1Value, rs2Value,
    output programCounter, immediate,
    input  shouldBranch, branchTarget,
    input  linkAddress, misaligned,
    input  branchCount, takenCount
  );

  modport slave (
    input  stall, flush, valid,
    input  isBranch, isJal, isJalr,
    input  funct3, rs1Value, rs2Value,
    input  programCounter, immediate,
    output shouldBranch, branchTarget,
    output linkAddress, misaligned,
    output branchCount, takenCount
  );
`else
  modport master (
    output stall, flush, valid,
    output isBranch, isJal, isJalr,
    output funct3, rs1Value, rs2Value,
    output programCounter, immediate,
    input  shouldBranch, branchTarget,
    input  linkAddress, misaligned
  );

  modport slave (
    input  stall, flush, valid,
    input  isBranch, isJal, isJalr,
    input  funct3, rs1Value, rs2Value,
    input  programCounter, immediate,
    output shouldBranch, branchTarget,
    output linkAddress, misaligned
  );
`endif

endinterface

// File: rtl/branch_comparator.sv
// Combinational RV32I branch condition evaluator.
// Shared with any future early-resolve stage.
module branch_comparator
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1Value,
  input  logic [XLEN-1:0] rs2Value,
  input  logic [2:0]      funct3,
  output logic            cond
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (rs1Value == rs2Value);
  assign lt  = ($signed(rs1Value) < $signed(rs2Value));
  assign ltu = (rs1Value < rs2Value);

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver with stall-tolerant redirect.
// Optional perf counters: BRANCH_PERF_COUNTER_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN = 32
`ifdef BRANCH_PERF_COUNTER_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK =
    XLEN'(INSTR_BYTES - 1);

  branch_state_t   state;
  logic [XLEN-1:0] pend_tgt;

  logic            cond;
  logic            take;
  logic            mis_now;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] tgt;

  branch_comparator #(.XLEN(XLEN)) u_cmp (
    .rs1Value (bus.rs1Value),
    .rs2Value (bus.rs2Value),
    .funct3   (bus.funct3),
    .cond     (cond)
  );

  assign br_tgt   = bus.programCounter + bus.immediate;
  assign jalr_sum = bus.rs1Value + bus.immediate;
  assign tgt      = bus.isJalr
                  ? (jalr_sum & ~XLEN'(1))
                  : br_tgt;

  assign take = bus.valid & ~bus.flush
              & (bus.isJal | bus.isJalr
                 | (bus.isBranch & cond));

  assign mis_now = take & (|(tgt & ALIGN_MASK));

  assign bus.linkAddress =
    bus.programCounter + XLEN'(INSTR_BYTES);

  assign bus.misaligned = mis_now & ~bus.stall & ~reset;

  // A held redirect wins over whatever the stage shows now.
  always_comb begin
    bus.shouldBranch = 1'b0;
    bus.branchTarget = '0;
    if (!reset && !bus.flush && !bus.stall) begin
      if (state == PENDING) begin
        bus.shouldBranch = 1'b1;
        bus.branchTarget = pend_tgt;
      end else if (take && !mis_now) begin
        bus.shouldBranch = 1'b1;
        bus.branchTarget = tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend_tgt <= '0;
    end else if (bus.flush) begin
      state    <= IDLE;
      pend_tgt <= '0;
    end else if (state == IDLE) begin
      if (bus.stall && take && !mis_now) begin
        state    <= PENDING;
        pend_tgt <= tgt;
      end
    end else if (!bus.stall) begin
      state <= IDLE;
    end
  end

`ifdef BRANCH_PERF_COUNTER_EN
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tk_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt <= '0;
      tk_cnt <= '0;
    end else begin
      if (bus.valid && bus.isBranch
          && !bus.stall && !bus.flush)
        br_cnt <= br_cnt + CNT_W'(1);
      if (bus.shouldBranch)
        tk_cnt <= tk_cnt + CNT_W'(1);
    end
  end

  assign bus.branchCount = br_cnt;
  assign bus.takenCount  = tk_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random bench for branch_resolve_unit.
// Counter checks compile in with BRANCH_PERF_COUNTER_EN.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BRANCH_PERF_COUNTER_EN
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
  branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
`else
  branch_resolve_unit_if #(.XLEN(32)) bus ();
  branch_resolve_unit #(.XLEN(32)) dut (
`endif
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: redirect awaiting release, plus counts.
  logic [31:0] held[$];
  logic [31:0] m_bc = 0;
  logic [31:0] m_tc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic bit cond_of(input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(input bit st, input bit fl,
                       input bit v, input bit b,
                       input bit j, input bit jr,
                       input logic [2:0] f3,
                       input logic [31:0] r1,
                       input logic [31:0] r2,
                       input logic [31:0] p,
                       input logic [31:0] im);
    bus.stall = st; bus.flush = fl; bus.valid = v;
    bus.isBranch = b; bus.isJal = j; bus.isJalr = jr;
    bus.funct3 = f3; bus.rs1Value = r1;
    bus.rs2Value = r2; bus.programCounter = p;
    bus.immediate = im;
  endtask

  // Check one cycle against the model, then advance it.
  task automatic step();
    bit tk, mis, esb;
    logic [31:0] t, etgt;
    #1;
    tk = bus.valid && !bus.flush && (bus.isJal
         || bus.isJalr || (bus.isBranch
         && cond_of(bus.funct3, bus.rs1Value,
                    bus.rs2Value)));
    if (bus.isJalr)
      t = (bus.rs1Value + bus.immediate) & ~32'd1;
    else
      t = bus.programCounter + bus.immediate;
    mis = tk && (t % 4 != 0);
    esb = 0; etgt = 0;
    if (!rst && !bus.flush && !bus.stall) begin
      if (held.size() != 0) begin
        esb = 1; etgt = held[0];
      end else if (tk && !mis) begin
        esb = 1; etgt = t;
      end
    end
    chk("shouldBranch", 32'(bus.shouldBranch), 32'(esb));
    chk("branchTarget", bus.branchTarget, etgt);
    chk("misaligned", 32'(bus.misaligned),
        32'(mis && !bus.stall && !rst));
    chk("linkAddress", bus.linkAddress,
        bus.programCounter + 32'd4);
`ifdef BRANCH_PERF_COUNTER_EN
    chk("branchCount", bus.branchCount, m_bc);
    chk("takenCount", bus.takenCount, m_tc);
`endif
    @(posedge clk);
    if (rst) begin
      held.delete(); m_bc = 0; m_tc = 0;
    end else begin
      if (bus.valid && bus.isBranch
          && !bus.stall && !bus.flush)
        m_bc++;
      if (esb) m_tc++;
      if (bus.flush)
        held.delete();
      else if (held.size() == 0) begin
        if (bus.stall && tk && !mis) held.push_back(t);
      end else if (!bus.stall)
        void'(held.pop_front());
    end
    @(negedge clk);
  endtask

  bit r_pst, r_pfl, r_st, r_fl, r_v, r_b, r_j, r_jr;
  logic [2:0]  r_f3;
  logic [31:0] r_r1, r_r2, r_p, r_im;
  int          r_k;

  initial begin
    apply(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h200, 8);
    #1 chk("rst_sb", 32'(bus.shouldBranch), 0);
    chk("rst_tgt", bus.branchTarget, 0);
    step(); step();
    rst = 1'b0;

    apply(0, 0, 1, 1, 0, 0, 3'd0, 5, 5, 32'h100, 32'h20);
    #1 chk("beq_sb", 32'(bus.shouldBranch), 1);
    chk("beq_tgt", bus.branchTarget, 32'h120);
    step();
    apply(0, 0, 1, 1, 0, 0, 3'd0, 5, 6, 32'h100, 32'h20);
    #1 chk("beq_nt", 32'(bus.shouldBranch), 0);
    step();

    apply(0, 0, 1, 1, 0, 0, 3'd4, '1, 1, 32'h100, 32'h20);
    #1 chk("blt", 32'(bus.shouldBranch), 1);
    step();
    apply(0, 0, 1, 1, 0, 0, 3'd6, '1, 1, 32'h100, 32'h20);
    #1 chk("bltu", 32'(bus.shouldBranch), 0);
    step();
    apply(0, 0, 1, 1, 0, 0, 3'd7, '1, 1, 32'h100, 32'h20);
    #1 chk("bgeu", 32'(bus.shouldBranch), 1);
    step();

    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 1, 1, 0, 0, 3'd1, 3, 4, 32'h300, 32'h40);
      #1 chk("bne_stall", 32'(bus.shouldBranch), 0);
      step();
    end
    apply(0, 0, 1, 1, 0, 0, 3'd1, 3, 4, 32'h300, 32'h40);
    #1 chk("bne_rel", 32'(bus.shouldBranch), 1);
    chk("bne_rel_tgt", bus.branchTarget, 32'h340);
    step();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h344, 0);
    #1 chk("bne_after", 32'(bus.shouldBranch), 0);
    step();

    apply(0, 0, 1, 0, 0, 1, 0, 32'h1003, 0, 32'h400, 0);
    #1 chk("jalr_mis", 32'(bus.misaligned), 1);
    chk("jalr_sb", 32'(bus.shouldBranch), 0);
    step();
    apply(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h200, 8);
    #1 chk("jal_tgt", bus.branchTarget, 32'h208);
    chk("jal_link", bus.linkAddress, 32'h204);
    step();

    apply(1, 0, 1, 1, 0, 0, 3'd1, 3, 4, 32'h500, 32'h10);
    step();
    apply(0, 1, 1, 1, 0, 0, 3'd1, 3, 4, 32'h500, 32'h10);
    #1 chk("flush_sb", 32'(bus.shouldBranch), 0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h504, 0);
    #1 chk("flush_after", 32'(bus.shouldBranch), 0);
    step();

    apply(1, 0, 1, 1, 0, 0, 3'd1, 3, 4, 32'h600, 32'h10);
    step();
    apply(0, 0, 1, 1, 0, 0, 3'd1, 3, 4, 32'h600, 32'h10);
    rst = 1'b1;
    #1 chk("rst_pend_sb", 32'(bus.shouldBranch), 0);
    chk("rst_pend_tgt", bus.branchTarget, 0);
    step();
    rst = 1'b0;
    apply(0, 0, 0, 1, 0, 0, 3'd1, 3, 4, 32'h600, 32'h10);
    #1 chk("rst_after", 32'(bus.shouldBranch), 0);
    step();

    apply(0, 0, 1, 1, 0, 0, 3'd0, 7, 7, 32'h700, 8);
    step();
    apply(0, 0, 1, 1, 0, 0, 3'd0, 7, 8, 32'h704, 8);
    step();
    apply(0, 0, 1, 1, 0, 0, 3'd1, 7, 8, 32'h708, 8);
    step();
    apply(0, 0, 1, 1, 0, 0, 3'd4, 9, 8, 32'h70c, 8);
    step();
    apply(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h710, 8);
    step();
`ifdef BRANCH_PERF_COUNTER_EN
    chk("perf_bc", bus.branchCount, 4);
    chk("perf_tc", bus.takenCount, 3);
`endif
    apply(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 8);
    #1 chk("link_wrap", bus.linkAddress, 0);
    chk("wrap_tgt", bus.branchTarget, 32'h4);
    step();

    r_pst = 0; r_pfl = 0;
    for (int i = 0; i < 500; i++) begin
      if (!(r_pst && !r_pfl)) begin
        r_v  = $urandom_range(0, 9) != 0;
        r_k  = $urandom_range(0, 3);
        r_b  = (r_k <= 1);
        r_j  = (r_k == 2);
        r_jr = (r_k == 3);
        r_f3 = 3'($urandom_range(0, 7));
        r_r1 = ($urandom_range(0, 1) != 0)
             ? $urandom : 32'($urandom_range(0, 15));
        r_r2 = ($urandom_range(0, 3) == 0)
             ? r_r1 : $urandom;
        r_p  = $urandom & ~32'd3;
        r_im = $urandom_range(0, 7) == 0
             ? $urandom & ~32'd1 : $urandom & ~32'd3;
        if (r_jr && $urandom_range(0, 1) != 0)
          r_r1 = r_r1 & ~32'd3;
      end
      r_st = $urandom_range(0, 9) < 3;
      r_fl = $urandom_range(0, 19) == 0;
      apply(r_st, r_fl, r_v, r_b, r_j, r_jr, r_f3,
            r_r1, r_r2, r_p, r_im);
      r_pst = r_st; r_pfl = r_fl;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch/jump resolver; successor to the single-condition zero-flag branch unit.
- Parametrised in data width; evaluates all six RV32I conditions from raw operands; resolves JAL/JALR targets and link address; flags misaligned targets.
- Holds a redirect raised under stall in a pending FSM until the pipeline can accept it.
- Drives fetch redirect (shouldBranch/branchTarget) and the hazard unit's flush.

Parameters:
- XLEN, 32, operand/address width.
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; execute-stage inputs held stable while high.
- flush  in  1  kill current resolution and any pending redirect (trap/exception).
- valid  in  1  execute stage holds a real instruction.
- isBranch  in  1  conditional branch.
- isJal  in  1  JAL.
- isJalr  in  1  JALR.
- funct3  in  3  branch condition selector.
- rs1Value  in  XLEN  first operand / JALR base.
- rs2Value  in  XLEN  second operand.
- programCounter  in  XLEN  PC of execute-stage instruction.
- immediate  in  XLEN  sign-extended offset.
- shouldBranch  out  1  redirect fetch this cycle.
- branchTarget  out  XLEN  redirect address.
- linkAddress  out  XLEN  programCounter+4 for JAL/JALR writeback.
- misaligned  out  1  taken target not 4-byte aligned (exception request).
- branchCount, takenCount  out  CNT_W each  (only with BRANCH_PERF_COUNTER_EN).

Behaviour:
- Conditions by funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. 010/011 are never taken.
- take = valid & !flush & (isJal | isJalr | (isBranch & cond)).
- Targets:
  - Branch/JAL target = programCounter+immediate, modulo 2^XLEN.
  - JALR target = (rs1Value+immediate) with bit0 cleared.
  - linkAddress = programCounter+4 (wraps), combinational, always driven.
- misalignedNow = take & (target[1:0] != 0). A misaligned resolution never redirects and never enters PENDING.
- FSM states: IDLE, PENDING. Registers: state, pendingTarget.
- IDLE:
  - stall=0 and take and !misalignedNow: shouldBranch=1 same cycle (combinational, zero latency), branchTarget=current target.
  - stall=1 and take and !misalignedNow: shouldBranch=0; capture target into pendingTarget; go to PENDING next edge.
- PENDING:
  - Current-cycle resolution is ignored; the held instruction is the same branch, and pendingTarget has priority.
  - stall=1: remain in PENDING, shouldBranch=0.
  - stall=0: shouldBranch=1 with branchTarget=pendingTarget for exactly one cycle; go to IDLE.
- misaligned = misalignedNow & !stall; asserted only in the unstalled cycle; combinational.
- flush=1, any state: shouldBranch=0 and misaligned=0 that cycle; state goes to IDLE and pendingTarget to 0 at the next edge. flush overrides stall and take.
- branchTarget is 0 when shouldBranch=0.
- Reset (async): state=IDLE, pendingTarget=0, counters=0. Outputs settle to shouldBranch=0, misaligned=0, branchTarget=0 immediately. Reset during PENDING discards the redirect.

Optional Feature:
- Macro BRANCH_PERF_COUNTER_EN.
- Defined:
  - branchCount increments by 1 on each edge where valid & isBranch & !stall & !flush.
  - takenCount increments on each edge where shouldBranch=1.
  - Both wrap at 2^CNT_W and are reset to 0.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package branch_pkg:
  - funct3 constants F3_BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Enum branch_state_t {IDLE, PENDING}.
  - Constant INSTR_BYTES=4.
- Sub-module branch_comparator (XLEN): purely combinational rs1/rs2/funct3 -> cond. Reusable by a future early-resolve stage.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, stall=0 -> shouldBranch=1, branchTarget=0x120 same cycle. Same stimulus with rs2=6 -> shouldBranch=0.
- BLT vs BLTU, rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken. BGEU taken.
- Taken BNE with stall=1 held 3 cycles, then stall=0 -> shouldBranch=0 during stall; single 1-cycle pulse at release with stored target; IDLE afterwards.
- JALR rs1=0x1003, imm=0 -> target 0x1002, misaligned=1, shouldBranch=0. JAL pc=0x200, imm=8 -> target 0x208, linkAddress=0x204.
- PENDING then flush=1 with stall=0 -> no redirect that cycle or later. Separately, reset asserted mid-PENDING -> outputs 0 immediately; no pulse after deassert.
- Perf counters (macro defined): 4 branches of which 2 taken, plus 1 JAL -> branchCount=4, takenCount=3. pc=0xFFFFFFFC JAL -> linkAddress=0 (wrap).
